// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: state encoding and port index constants shared by the memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: two-way winner selection; on contention the port not granted last wins.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic v0,
    input  logic v1,
    input  logic last,
    output logic gnt,
    output logic gnt_valid
);

    assign gnt_valid = v0 | v1;
    assign gnt       = (v0 && v1) ? ((last == PORT0) ? PORT1 : PORT0) : (v1 ? PORT1 : PORT0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter onto a single-port RAM with fixed IDLE/ACCESS/RESP latency.
// Define MEM_ARB_RR_EN for round-robin on contention; otherwise port 0 has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int ADDRESS_SIZE = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    p0_req_valid,
    input  logic                    p0_req_write,
    input  logic [ADDRESS_SIZE-1:0] p0_req_address,
    input  logic [WORD_SIZE-1:0]    p0_req_data,
    output logic                    p0_req_ready,
    output logic                    p0_rsp_valid,
    output logic [WORD_SIZE-1:0]    p0_rsp_data,
    input  logic                    p1_req_valid,
    input  logic                    p1_req_write,
    input  logic [ADDRESS_SIZE-1:0] p1_req_address,
    input  logic [WORD_SIZE-1:0]    p1_req_data,
    output logic                    p1_req_ready,
    output logic                    p1_rsp_valid,
    output logic [WORD_SIZE-1:0]    p1_rsp_data,
    output logic                    ram_read,
    output logic                    ram_write,
    output logic [ADDRESS_SIZE-1:0] ram_address,
    output logic [WORD_SIZE-1:0]    ram_in_data,
    input  logic [WORD_SIZE-1:0]    ram_out_data
);

    state_t state;
    logic   wr;
    logic   win;
    logic   gnt;
    logic   gnt_valid;
    logic   last_grant;
    logic   accept;
    logic   sel_write;

    // The winner register doubles as last-grant: it resets to port 1 and reloads on every accept.
`ifdef MEM_ARB_RR_EN
    assign last_grant = win;
`else
    assign last_grant = PORT1;
`endif

    mem_arb_pick u_pick (
        .v0        (p0_req_valid),
        .v1        (p1_req_valid),
        .last      (last_grant),
        .gnt       (gnt),
        .gnt_valid (gnt_valid)
    );

    assign accept       = (state == IDLE) && gnt_valid;
    assign p0_req_ready = accept && (gnt == PORT0);
    assign p1_req_ready = accept && (gnt == PORT1);
    assign sel_write    = (gnt == PORT1) ? p1_req_write : p0_req_write;
    // RAM read data only lands during RESP, so response data is steered combinationally.
    assign p0_rsp_data  = (p0_rsp_valid && !wr) ? ram_out_data : '0;
    assign p1_rsp_data  = (p1_rsp_valid && !wr) ? ram_out_data : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            wr           <= 1'b0;
            win          <= PORT1;
            ram_read     <= 1'b0;
            ram_write    <= 1'b0;
            ram_address  <= '0;
            ram_in_data  <= '0;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
        end else begin
            ram_read     <= 1'b0;
            ram_write    <= 1'b0;
            p0_rsp_valid <= 1'b0;
            p1_rsp_valid <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    state       <= ACCESS;
                    wr          <= sel_write;
                    win         <= gnt;
                    ram_address <= (gnt == PORT1) ? p1_req_address : p0_req_address;
                    ram_in_data <= (gnt == PORT1) ? p1_req_data : p0_req_data;
                    ram_read    <= !sel_write;
                    ram_write   <= sel_write;
                end
                ACCESS: begin
                    state        <= RESP;
                    p0_rsp_valid <= (win == PORT0);
                    p1_rsp_valid <= (win == PORT1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a registered-read RAM model.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        p0_req_valid, p0_req_write, p0_req_ready, p0_rsp_valid;
    logic [15:0] p0_req_address, p0_req_data, p0_rsp_data;
    logic        p1_req_valid, p1_req_write, p1_req_ready, p1_rsp_valid;
    logic [15:0] p1_req_address, p1_req_data, p1_rsp_data;
    logic        ram_read, ram_write;
    logic [15:0] ram_address, ram_in_data, ram_out_data;
    logic [15:0] mem [0:65535];
    int          checks = 0;
    int          passes = 0;
    logic [3:0]  order;

    always #5 clock = ~clock;

    mem_arbiter #(.WORD_SIZE(16), .ADDRESS_SIZE(16)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .p0_req_valid   (p0_req_valid),
        .p0_req_write   (p0_req_write),
        .p0_req_address (p0_req_address),
        .p0_req_data    (p0_req_data),
        .p0_req_ready   (p0_req_ready),
        .p0_rsp_valid   (p0_rsp_valid),
        .p0_rsp_data    (p0_rsp_data),
        .p1_req_valid   (p1_req_valid),
        .p1_req_write   (p1_req_write),
        .p1_req_address (p1_req_address),
        .p1_req_data    (p1_req_data),
        .p1_req_ready   (p1_req_ready),
        .p1_rsp_valid   (p1_rsp_valid),
        .p1_rsp_data    (p1_rsp_data),
        .ram_read       (ram_read),
        .ram_write      (ram_write),
        .ram_address    (ram_address),
        .ram_in_data    (ram_in_data),
        .ram_out_data   (ram_out_data)
    );

    always @(posedge clock) begin
        if (ram_write) mem[ram_address] <= ram_in_data;
        if (ram_read) ram_out_data <= mem[ram_address];
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            chk1("strobe_exclusive", ram_read && ram_write, 1'b0);
            chk1("rsp_exclusive", p0_rsp_valid && p1_rsp_valid, 1'b0);
            chk1("ready_exclusive", p0_req_ready && p1_req_ready, 1'b0);
        end
    end

    task automatic drive(input logic p, input logic v, input logic w, input logic [15:0] a, input logic [15:0] d);
        if (p) begin
            p1_req_valid = v; p1_req_write = w; p1_req_address = a; p1_req_data = d;
        end else begin
            p0_req_valid = v; p0_req_write = w; p0_req_address = a; p0_req_data = d;
        end
    endtask

    // Full transaction from one port alone: accept at T, strobe at T+1, response at T+2.
    task automatic xact(input logic p, input logic w, input logic [15:0] a, input logic [15:0] d, input logic [15:0] exp);
        drive(p, 1'b1, w, a, d);
        #1;
        chk1("req_ready_win", p ? p1_req_ready : p0_req_ready, 1'b1);
        chk1("req_ready_lose", p ? p0_req_ready : p1_req_ready, 1'b0);
        @(posedge clock); #1;
        drive(p, 1'b0, ~w, ~a, ~d);
        chk1("ram_read", ram_read, !w);
        chk1("ram_write", ram_write, w);
        chk16("ram_address", ram_address, a);
        chk16("ram_in_data", ram_in_data, d);
        @(posedge clock); #1;
        chk1("rsp_valid_win", p ? p1_rsp_valid : p0_rsp_valid, 1'b1);
        chk1("rsp_valid_lose", p ? p0_rsp_valid : p1_rsp_valid, 1'b0);
        chk16("rsp_data_win", p ? p1_rsp_data : p0_rsp_data, w ? 16'h0000 : exp);
        chk16("rsp_data_lose", p ? p0_rsp_data : p1_rsp_data, 16'h0000);
        chk1("strobe_off_resp", ram_read | ram_write, 1'b0);
        @(posedge clock); #1;
        chk1("rsp_valid_drop", p ? p1_rsp_valid : p0_rsp_valid, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0003] = 16'hC040;
        mem[16'h0040] = 16'h5555;
        ram_out_data = 16'h0000;
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1;
        chk1("rst_ram_read", ram_read, 1'b0);
        chk1("rst_ram_write", ram_write, 1'b0);
        chk16("rst_ram_address", ram_address, 16'h0000);
        chk16("rst_ram_in_data", ram_in_data, 16'h0000);
        chk1("rst_p0_rsp_valid", p0_rsp_valid, 1'b0);
        chk1("rst_p1_rsp_valid", p1_rsp_valid, 1'b0);
        chk16("rst_p0_rsp_data", p0_rsp_data, 16'h0000);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        xact(1'b0, 1'b0, 16'h0003, 16'h0000, 16'hC040);
        xact(1'b1, 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
        xact(1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF);
        xact(1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000);

        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
`ifdef MEM_ARB_RR_EN
        order = 4'b1010;
`else
        order = 4'b0000;
`endif
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        drive(1'b1, 1'b1, 1'b0, 16'h0030, 16'h0000);
        for (int g = 0; g < 4; g++) begin
            #1;
            chk1("contend_p0_ready", p0_req_ready, !order[g]);
            chk1("contend_p1_ready", p1_req_ready, order[g]);
            @(posedge clock); #1;
            chk1("access_p0_ready", p0_req_ready, 1'b0);
            chk1("access_p1_ready", p1_req_ready, 1'b0);
            chk1("contend_ram_read", ram_read, 1'b1);
            chk16("contend_address", ram_address, order[g] ? 16'h0030 : 16'h0020);
            @(posedge clock); #1;
            chk1("resp_p1_ready", p1_req_ready, 1'b0);
            chk1("contend_p0_rsp", p0_rsp_valid, !order[g]);
            chk1("contend_p1_rsp", p1_rsp_valid, order[g]);
            @(posedge clock);
        end
        #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(posedge clock); #1;

        drive(1'b1, 1'b1, 1'b1, 16'h0040, 16'h1234);
        #1;
        chk1("abort_accept", p1_req_ready, 1'b1);
        @(posedge clock); #1;
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk1("abort_ram_write_on", ram_write, 1'b1);
        reset_n = 1'b0;
        #1;
        chk1("abort_ram_write_drop", ram_write, 1'b0);
        chk16("abort_ram_address", ram_address, 16'h0000);
        @(posedge clock); #1;
        chk1("abort_no_rsp_rst", p1_rsp_valid, 1'b0);
        reset_n = 1'b1;
        @(posedge clock); #1;
        chk1("abort_no_rsp_p1", p1_rsp_valid, 1'b0);
        chk1("abort_no_rsp_p0", p0_rsp_valid, 1'b0);
        xact(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h5555);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
